// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, flag bit positions, FSM encoding.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    // Opcode map, unchanged from the 8-bit registered ALU
    localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'h2;
    localparam logic [OP_W-1:0] ALU_SHL  = 4'h3;
    localparam logic [OP_W-1:0] ALU_SHR  = 4'h4;
    localparam logic [OP_W-1:0] ALU_INCA = 4'h5;
    localparam logic [OP_W-1:0] ALU_INCB = 4'h6;
    localparam logic [OP_W-1:0] ALU_DECA = 4'h7;
    localparam logic [OP_W-1:0] ALU_DECB = 4'h8;
    localparam logic [OP_W-1:0] ALU_EQ   = 4'h9;
    localparam logic [OP_W-1:0] ALU_GT   = 4'hA;
    localparam logic [OP_W-1:0] ALU_LT   = 4'hB;
    localparam logic [OP_W-1:0] ALU_OR0  = 4'hC;
    localparam logic [OP_W-1:0] ALU_AND  = 4'hD;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'hE;
    localparam logic [OP_W-1:0] ALU_PASS = 4'hF;

    // Bit positions inside OUT_FLAGS = {OVF,NEG,CARRY,ZERO}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the opcodes that go through the shared adder/subtractor
    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == ALU_ADD)  || (op == ALU_SUB)  ||
               (op == ALU_INCA) || (op == ALU_INCB) ||
               (op == ALU_DECA) || (op == ALU_DECB);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// o_done_c / o_prod_c are combinational: o_prod_c holds the finished product in the cycle o_done_c is high.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done_c,
    output logic [2*WIDTH-1:0]   o_prod_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    // One shift-add step: the multiplier sits in the low half and is consumed LSB first
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        w_last     = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Operand load on start, then WIDTH iterations
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_acc   <= {{WIDTH{1'b0}}, i_b};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done_c = w_last;
    assign o_prod_c = w_acc_next;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, status flags and an iterative multiplier.
// Optional build macro ALU_SATURATE_EN: add/sub/inc/dec clamp unsigned instead of wrapping.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          MUL_FULL = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   IN_A,
    input  logic [WIDTH-1:0]   IN_B,
    input  logic [OP_W-1:0]    ALU_Op_Code,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   OUT_RESULT,
    output logic [WIDTH-1:0]   OUT_RESULT_HI,
    output logic [FLAG_W-1:0]  OUT_FLAGS,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic [FLAG_W-1:0]  r_flags;
    logic               r_valid;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic               w_sub;
    logic               w_arith;
    logic [WIDTH:0]     w_sum;
    logic               w_arith_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [FLAG_W-1:0]  w_flags;
    logic [FLAG_W-1:0]  w_mul_flags;

    // Handshake: a new command may enter while idle or while the held result retires
    always_comb begin
        IN_READY    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && OUT_READY);
        w_accept    = IN_VALID && IN_READY;
        w_mul_start = w_accept && (ALU_Op_Code == ALU_MUL);
    end

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk    (CLK),
        .i_rst    (RESET),
        .i_start  (w_mul_start),
        .i_a      (IN_A),
        .i_b      (IN_B),
        .o_busy   (w_mul_busy),
        .o_done_c (w_mul_done),
        .o_prod_c (w_prod)
    );

    // Operand steering for the shared adder/subtractor
    always_comb begin
        w_x     = IN_A;
        w_y     = IN_B;
        w_sub   = 1'b0;
        w_arith = is_arith(ALU_Op_Code);
        case (ALU_Op_Code)
            ALU_SUB:  w_sub = 1'b1;
            ALU_INCA: w_y   = WIDTH'(1);
            ALU_INCB: begin
                w_x = IN_B;
                w_y = WIDTH'(1);
            end
            ALU_DECA: begin
                w_y   = WIDTH'(1);
                w_sub = 1'b1;
            end
            ALU_DECB: begin
                w_x   = IN_B;
                w_y   = WIDTH'(1);
                w_sub = 1'b1;
            end
            default: ;
        endcase
        // Bit WIDTH is carry-out on add and borrow on subtract
        w_sum = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
        w_arith_ovf = w_sub ? ((w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                            : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));
    end

    // Single-cycle result and raw carry/overflow selection
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (ALU_Op_Code)
            ALU_ADD, ALU_SUB, ALU_INCA, ALU_INCB, ALU_DECA, ALU_DECB: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_arith_ovf;
            end
            ALU_SHL: begin
                w_res   = {IN_A[WIDTH-2:0], 1'b0};
                w_carry = IN_A[WIDTH-1];
            end
            ALU_SHR: begin
                w_res   = {1'b0, IN_A[WIDTH-1:1]};
                w_carry = IN_A[0];
            end
            ALU_EQ:   w_res = WIDTH'(IN_A == IN_B);
            ALU_GT:   w_res = WIDTH'(IN_A > IN_B);
            ALU_LT:   w_res = WIDTH'(IN_A < IN_B);
            ALU_OR0:  w_res = WIDTH'(IN_A[0] | IN_B[0]);
            ALU_AND:  w_res = IN_A & IN_B;
            ALU_XOR:  w_res = IN_A ^ IN_B;
            ALU_PASS: w_res = IN_A;
            default:  w_res = '0;
        endcase
`ifdef ALU_SATURATE_EN
        // Clamp on unsigned overflow/underflow; carry and overflow keep the raw condition
        if (w_arith && w_sum[WIDTH]) begin
            w_res = w_sub ? '0 : '1;
        end
`endif
    end

    // Flag vectors for the single-cycle result and for the multiplier product
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_C] = w_carry;
        w_flags[FLAG_N] = w_res[WIDTH-1];
        w_flags[FLAG_V] = w_ovf;

        w_mul_flags         = '0;
        w_mul_flags[FLAG_Z] = (w_prod[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_C] = (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLAG_N] = w_prod[WIDTH-1];
    end

    // Control FSM and output register; results are held until OUT_READY retires them
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (ALU_Op_Code == ALU_MUL) begin
                            r_valid <= 1'b0;
                            r_state <= ST_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_flags     <= w_flags;
                            r_valid     <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if ((r_state == ST_DONE) && OUT_READY) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_prod[WIDTH-1:0];
                        r_result_hi <= MUL_FULL ? w_prod[2*WIDTH-1:WIDTH] : '0;
                        r_flags     <= w_mul_flags;
                        r_valid     <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (!w_mul_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign OUT_RESULT    = r_result;
    assign OUT_RESULT_HI = r_result_hi;
    assign OUT_FLAGS     = r_flags;
    assign OUT_VALID     = r_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, MUL_FULL=1); flags are {V,N,C,Z}.
module tb_alu_seq;
    import alu_pkg::*;

    logic       CLK;
    logic       RESET;
    logic [7:0] IN_A;
    logic [7:0] IN_B;
    logic [3:0] ALU_Op_Code;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OUT_RESULT;
    logic [7:0] OUT_RESULT_HI;
    logic [3:0] OUT_FLAGS;
    logic       OUT_VALID;
    logic       OUT_READY;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t vt[20];

    alu_seq #(
        .WIDTH    (8),
        .MUL_FULL (1'b1)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_A          (IN_A),
        .IN_B          (IN_B),
        .ALU_Op_Code   (ALU_Op_Code),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .OUT_RESULT    (OUT_RESULT),
        .OUT_RESULT_HI (OUT_RESULT_HI),
        .OUT_FLAGS     (OUT_FLAGS),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue a MUL from IDLE and check busy window, latency and product
    task automatic do_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] flg);
        int lat;
        int n_low;
        IN_VALID    = 1'b1;
        ALU_Op_Code = ALU_MUL;
        IN_A        = a;
        IN_B        = b;
        step();
        IN_VALID = 1'b0;
        IN_A     = 8'h00;
        IN_B     = 8'h00;
        lat      = 1;
        n_low    = 0;
        while (!OUT_VALID && lat < 30) begin
            if (!IN_READY) n_low++;
            step();
            lat++;
        end
        chk({name, "_lat"},   32'(lat),           32'd9);
        chk({name, "_busy"},  32'(n_low),         32'd8);
        chk({name, "_valid"}, 32'(OUT_VALID),     32'd1);
        chk({name, "_lo"},    32'(OUT_RESULT),    32'(lo));
        chk({name, "_hi"},    32'(OUT_RESULT_HI), 32'(hi));
        chk({name, "_flg"},   32'(OUT_FLAGS),     32'(flg));
        step();
        chk({name, "_retire"}, 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        logic [3:0] s_op [5];
        logic [7:0] s_res [5];
        int stale;

`ifdef ALU_SATURATE_EN
        vt[0]  = '{ALU_ADD,  8'hFF, 8'h01, 8'hFF, 4'b0110};
        vt[3]  = '{ALU_SUB,  8'h03, 8'h05, 8'h00, 4'b0011};
        vt[7]  = '{ALU_INCA, 8'hFF, 8'h12, 8'hFF, 4'b0110};
        vt[9]  = '{ALU_DECA, 8'h00, 8'h34, 8'h00, 4'b0011};
`else
        vt[0]  = '{ALU_ADD,  8'hFF, 8'h01, 8'h00, 4'b0011};
        vt[3]  = '{ALU_SUB,  8'h03, 8'h05, 8'hFE, 4'b0110};
        vt[7]  = '{ALU_INCA, 8'hFF, 8'h12, 8'h00, 4'b0011};
        vt[9]  = '{ALU_DECA, 8'h00, 8'h34, 8'hFF, 4'b0110};
`endif
        vt[1]  = '{ALU_ADD,  8'h7F, 8'h01, 8'h80, 4'b1100};
        vt[2]  = '{ALU_SUB,  8'h80, 8'h01, 8'h7F, 4'b1000};
        vt[4]  = '{ALU_SHL,  8'h81, 8'h00, 8'h02, 4'b0010};
        vt[5]  = '{ALU_SHR,  8'h81, 8'h00, 8'h40, 4'b0010};
        vt[6]  = '{ALU_ADD,  8'h00, 8'h00, 8'h00, 4'b0001};
        vt[8]  = '{ALU_INCB, 8'h00, 8'h7F, 8'h80, 4'b1100};
        vt[10] = '{ALU_DECB, 8'h11, 8'h80, 8'h7F, 4'b1000};
        vt[11] = '{ALU_EQ,   8'h5A, 8'h5A, 8'h01, 4'b0000};
        vt[12] = '{ALU_EQ,   8'h5A, 8'h5B, 8'h00, 4'b0001};
        vt[13] = '{ALU_GT,   8'h80, 8'h7F, 8'h01, 4'b0000};
        vt[14] = '{ALU_LT,   8'h80, 8'h7F, 8'h00, 4'b0001};
        vt[15] = '{ALU_OR0,  8'h02, 8'h03, 8'h01, 4'b0000};
        vt[16] = '{ALU_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000};
        vt[17] = '{ALU_XOR,  8'hF0, 8'hF0, 8'h00, 4'b0001};
        vt[18] = '{ALU_PASS, 8'h9C, 8'h00, 8'h9C, 4'b0100};
        vt[19] = '{ALU_XOR,  8'hA5, 8'h0F, 8'hAA, 4'b0100};

        s_op[0] = ALU_ADD; s_res[0] = 8'd8;
        s_op[1] = ALU_EQ;  s_res[1] = 8'd0;
        s_op[2] = ALU_GT;  s_res[2] = 8'd1;
        s_op[3] = ALU_LT;  s_res[3] = 8'd0;
        s_op[4] = ALU_OR0; s_res[4] = 8'd1;

        // Reset state
        RESET       = 1'b1;
        IN_VALID    = 1'b0;
        IN_A        = 8'h00;
        IN_B        = 8'h00;
        ALU_Op_Code = 4'h0;
        OUT_READY   = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(OUT_VALID),     32'd0);
        chk("rst_res",   32'(OUT_RESULT),    32'd0);
        chk("rst_hi",    32'(OUT_RESULT_HI), 32'd0);
        chk("rst_flg",   32'(OUT_FLAGS),     32'd0);
        RESET = 1'b0;
        step();
        chk("rst_ready", 32'(IN_READY), 32'd1);

        // Single-cycle ops, issued back to back with the consumer always ready
        for (int i = 0; i < 20; i++) begin
            IN_VALID    = 1'b1;
            ALU_Op_Code = vt[i].op;
            IN_A        = vt[i].a;
            IN_B        = vt[i].b;
            chk($sformatf("vec%0d_rdy", i), 32'(IN_READY), 32'd1);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(OUT_VALID),     32'd1);
            chk($sformatf("vec%0d_res", i),   32'(OUT_RESULT),    32'(vt[i].res));
            chk($sformatf("vec%0d_hi", i),    32'(OUT_RESULT_HI), 32'd0);
            chk($sformatf("vec%0d_flg", i),   32'(OUT_FLAGS),     32'(vt[i].flg));
        end
        IN_VALID = 1'b0;
        step();
        chk("vec_end_valid", 32'(OUT_VALID), 32'd0);

        // Backpressure: result held, no new command taken while stalled
        OUT_READY   = 1'b0;
        IN_VALID    = 1'b1;
        ALU_Op_Code = ALU_XOR;
        IN_A        = 8'h0F;
        IN_B        = 8'h3C;
        step();
        ALU_Op_Code = ALU_ADD;
        IN_A        = 8'h01;
        IN_B        = 8'h01;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(OUT_VALID),  32'd1);
            chk($sformatf("bp%0d_res", k),   32'(OUT_RESULT), 32'h33);
            chk($sformatf("bp%0d_flg", k),   32'(OUT_FLAGS),  32'd0);
            chk($sformatf("bp%0d_rdy", k),   32'(IN_READY),   32'd0);
            step();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        step();
        chk("bp_retire_valid", 32'(OUT_VALID),  32'd0);
        chk("bp_retire_res",   32'(OUT_RESULT), 32'h33);
        step();
        chk("bp_single_valid", 32'(OUT_VALID), 32'd0);

        // Streaming: one result per cycle
        IN_A = 8'd5;
        IN_B = 8'd3;
        for (int i = 0; i < 5; i++) begin
            IN_VALID    = 1'b1;
            ALU_Op_Code = s_op[i];
            step();
            chk($sformatf("strm%0d_valid", i), 32'(OUT_VALID),  32'd1);
            chk($sformatf("strm%0d_res", i),   32'(OUT_RESULT), 32'(s_res[i]));
        end
        IN_VALID = 1'b0;
        step();
        chk("strm_end_valid", 32'(OUT_VALID), 32'd0);

        // Multiplier
        do_mul("mul_ff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010);
        do_mul("mul_8f", 8'h0D, 8'h0B, 8'h8F, 8'h00, 4'b0100);
        do_mul("mul_z",  8'h10, 8'h20, 8'h00, 8'h02, 4'b0011);

        // Leave a nonzero held result, then reset on cycle 4 of a multiply
        IN_VALID    = 1'b1;
        ALU_Op_Code = ALU_PASS;
        IN_A        = 8'hC3;
        step();
        chk("pre_rst_res", 32'(OUT_RESULT), 32'hC3);
        ALU_Op_Code = ALU_MUL;
        IN_A        = 8'hFF;
        IN_B        = 8'hFF;
        step();
        IN_VALID = 1'b0;
        step();
        step();
        step();
        chk("mulrst_busy", 32'(IN_READY), 32'd0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("mulrst_valid", 32'(OUT_VALID),     32'd0);
        chk("mulrst_res",   32'(OUT_RESULT),    32'd0);
        chk("mulrst_hi",    32'(OUT_RESULT_HI), 32'd0);
        chk("mulrst_flg",   32'(OUT_FLAGS),     32'd0);
        chk("mulrst_rdy",   32'(IN_READY),      32'd1);
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (OUT_VALID) stale++;
        end
        chk("mulrst_stale", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
